// File: rtl/fifo_ctrl.sv
// Circular-FIFO sequencer for an external dual-port memory. It drives the memory
// write/read strobes and pointers, tracks occupancy, and latches illegal accesses.
module fifo_ctrl #(
  parameter int unsigned DATA_WIDTH = 12,
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned DEPTH      = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [ADDR_WIDTH:0]   af_thresh,
  input  logic [ADDR_WIDTH:0]   ae_thresh,
  output logic                  wr_e,
  output logic                  rd_e,
  output logic [ADDR_WIDTH-1:0] wr_ptr,
  output logic [ADDR_WIDTH-1:0] rd_ptr,
  output logic [DATA_WIDTH-1:0] data_w,
  output logic                  pop_valid,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  error
);

  localparam logic [1:0] ST_INIT   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_ERROR  = 2'd2;

  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  pop_valid_q;

  logic active;
  logic push_acc, pop_acc;
  logic overflow, underflow;

  // Occupancy flags
  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= af_thresh);
  assign almost_empty = (count_q <= ae_thresh);
  assign count        = count_q;

  // Legality is decided per request, so a simultaneous push+pop at a boundary
  // still lets the legal half through while the illegal half traps.
  assign active    = (state_q == ST_ACTIVE) && !reset;
  assign push_acc  = active && push && !full;
  assign pop_acc   = active && pop && !empty;
  assign overflow  = active && push && full;
  assign underflow = active && pop && empty;

  // Memory drive
  assign wr_e   = push_acc;
  assign rd_e   = pop_acc;
  assign wr_ptr = reset ? '0 : wr_ptr_q;
  assign rd_ptr = reset ? '0 : rd_ptr_q;
  assign data_w = push_acc ? data_in : '0;

  assign pop_valid = pop_valid_q;
  assign error     = (state_q == ST_ERROR);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_INIT:   state_d = ST_ACTIVE;
      ST_ACTIVE: if (overflow || underflow) state_d = ST_ERROR;
      ST_ERROR:  state_d = ST_ERROR;
      default:   state_d = ST_INIT;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_acc) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
    if (pop_acc)  rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
    unique case ({push_acc, pop_acc})
      2'b10:   count_d = count_q + (ADDR_WIDTH+1)'(1);
      2'b01:   count_d = count_q - (ADDR_WIDTH+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_INIT;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      pop_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      pop_valid_q <= pop_acc;
    end
  end

endmodule

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
- Controller that sequences the 8-entry x 12-bit dual-port memory as a circular FIFO for the transaction-layer queues.
- Accepts push/pop requests from the upstream and downstream stages.
- Generates the memory's wr_e/rd_e/wr_ptr/rd_ptr/data_w controls, tracks occupancy, produces full/empty/almost flags, and traps illegal accesses in a sticky error state.

Parameters:
- DATA_WIDTH, 12, width of the data word passed to the memory.
- ADDR_WIDTH, 3, width of the memory pointers.
- DEPTH, 8, number of entries; must equal 2**ADDR_WIDTH.

Ports:
- clk  input  1  single clock, all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- push  input  1  write request; the word is on data_in in the same cycle.
- pop  input  1  read request.
- data_in  input  DATA_WIDTH  write data.
- af_thresh  input  ADDR_WIDTH+1  almost-full threshold.
- ae_thresh  input  ADDR_WIDTH+1  almost-empty threshold.
- wr_e  output  1  memory write enable.
- rd_e  output  1  memory read enable.
- wr_ptr  output  ADDR_WIDTH  memory write address.
- rd_ptr  output  ADDR_WIDTH  memory read address.
- data_w  output  DATA_WIDTH  memory write data.
- pop_valid  output  1  memory read data valid; registered.
- count  output  ADDR_WIDTH+1  occupancy, range 0..DEPTH.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= af_thresh.
- almost_empty  output  1  count <= ae_thresh.
- error  output  1  sticky: overflow or underflow attempted.

Behaviour:
- Reset, synchronous:
  - Internal state = INIT; write/read pointer registers = 0; count = 0; pop_valid = 0; error = 0.
  - Outputs during reset: wr_e = 0, rd_e = 0, wr_ptr = 0, rd_ptr = 0, data_w = 0.
  - Flags are combinational from count: full = 0, empty = 1, almost_empty = 1; almost_full = 1 only if af_thresh == 0.
  - A reset mid-operation discards all contents and pointers in the same edge.
- States:
  - INIT: one cycle after reset release; push and pop are ignored, not errors. Next state is ACTIVE.
  - ACTIVE: normal operation.
  - ERROR: entered from ACTIVE on illegal access; exit only by reset.
- Accept rules in ACTIVE:
  - Push is accepted when push && !full.
  - Pop is accepted when pop && !empty.
  - Push while full → overflow: not written, state goes to ERROR at the next edge.
  - Pop while empty → underflow: same handling, state goes to ERROR at the next edge.
  - Simultaneous push+pop when full: the pop is accepted, the push is overflow → ERROR.
  - Simultaneous push+pop when empty: the push is accepted, the pop is underflow → ERROR.
  - Both legal together: both are accepted and count is unchanged.
- Memory drive, combinational from the current cycle:
  - wr_e = accepted push; wr_ptr = the write pointer register; data_w = data_in when wr_e, else 0.
  - rd_e = accepted pop; rd_ptr = the read pointer register.
- Pointer and count update at the posedge:
  - On an accepted push, the write pointer increments mod DEPTH (7 → 0).
  - On an accepted pop, the read pointer increments mod DEPTH.
  - count changes by +1 (push only), −1 (pop only) or 0 (both or neither).
- Read latency: pop_valid is registered = rd_e of the previous cycle. Read data appears from the memory one cycle after rd_e.
- ERROR state:
  - error = 1.
  - wr_e = rd_e = 0 regardless of requests.
  - Pointers and count are frozen, and pop_valid returns to 0 one cycle after entry.
- Thresholds are sampled live and not registered. A threshold greater than DEPTH means almost_full is never asserted.

Test Plan:
- Reset, then INIT → push=1, data_in=0x00A during the INIT cycle is ignored: wr_e=0, count=0, empty=1, error=0.
- Eight pushes 0x001..0x008 in ACTIVE:
  - wr_ptr steps 0..7, count reaches 8, full=1.
  - With af_thresh=6, almost_full rises when count becomes 6.
- From full, eight pops:
  - rd_ptr steps 0..7, pop_valid lags rd_e by 1 cycle, empty=1 at the end, error=0.
  - Wrap check: push 3 more words → wr_ptr = 0,1,2.
- With count=4, push+pop in the same cycle for 10 cycles → count stays 4; wr_ptr and rd_ptr each advance 10 mod 8 = 2 positions; wr_e=rd_e=1 every cycle.
- Push when full → error=1 next cycle and rd_e/wr_e held 0 on later requests. Pop when empty (fresh reset) → same.
- From ERROR, assert reset for 1 cycle → count=0, error=0, INIT, then ACTIVE; a push of 0x0BB writes at wr_ptr=0.
